oled_screen_arbiter: RTL and testbench

Round-robin arbiter that shares one PmodOLED text-screen controller among NREQ requesters. Each requester offers a 64-character (512-bit, 4 pages × 16 ASCII bytes, MSB = page 0 col 0) screen image. The arbiter grants one requester, latches its image and drives the controller's EN/FIN handshake. It then holds the picture for a minimum dwell time before re-arbitrating. It sits between application logic and the OLED controller, in the same clock domain.

---
 rtl/oled_screen_arbiter.sv | 147 ++++++++++++++
 tb/tb_oled_screen_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/oled_screen_arbiter.sv
// Round-robin arbiter sharing one PmodOLED text controller; latches the winner's 512-bit image and runs EN/FIN.
// Latency: grant, OLED_EN and OLED_STRING one cycle after REQ is sampled in IDLE; DONE one cycle after OLED_FIN.
// Backpressure: requests wait (REQ held) until IDLE; OLED_ARB_PRIO0_EN gives requester 0 fixed top priority.
module oled_screen_arbiter #(
    parameter int NREQ         = 4,
    parameter int DWELL_CYCLES = 100000000
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [NREQ-1:0]     REQ,
    input  logic [NREQ*512-1:0] REQ_STRING,
    output logic [NREQ-1:0]     GNT,
    output logic [NREQ-1:0]     DONE,
    output logic                OLED_EN,
    input  logic                OLED_FIN,
    output logic [511:0]        OLED_STRING,
    output logic                BUSY
);

    localparam int PW = $clog2(NREQ);
    localparam int CW = (DWELL_CYCLES > 0) ? $clog2(DWELL_CYCLES + 1) : 1;
    localparam logic [CW-1:0] DWELL_LOAD = (DWELL_CYCLES > 0) ? CW'(DWELL_CYCLES - 1) : '0;

`ifdef OLED_ARB_PRIO0_EN
    localparam logic [NREQ-1:0] RR_MASK = {{(NREQ-1){1'b1}}, 1'b0};
`else
    localparam logic [NREQ-1:0] RR_MASK = {NREQ{1'b1}};
`endif

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SHOW    = 2'd1,
        S_RELEASE = 2'd2,
        S_DWELL   = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   ptr;
    logic [CW-1:0]   cnt;
    logic [NREQ-1:0] gnt_q;
    logic [NREQ-1:0] done_q;
    logic            en_q;
    logic [511:0]    str_q;

    logic [PW-1:0]   win;
    logic            win_prio;
    logic [NREQ-1:0] req_rr;
    logic [PW:0]     scan;
    logic            found;

    // Scan upward from the pointer with wrap; requester 0 is masked out of the scan when it has fixed priority.
    always_comb begin
        win      = '0;
        win_prio = 1'b0;
        found    = 1'b0;
        scan     = '0;
        req_rr   = REQ & RR_MASK;
`ifdef OLED_ARB_PRIO0_EN
        if (REQ[0]) begin
            win_prio = 1'b1;
            found    = 1'b1;
        end
`endif
        for (int k = 0; k < NREQ; k++) begin
            scan = {1'b0, ptr} + (PW+1)'(k);
            if (scan >= (PW+1)'(NREQ))
                scan = scan - (PW+1)'(NREQ);
            if (!found && req_rr[scan[PW-1:0]]) begin
                win   = scan[PW-1:0];
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (|REQ) state_nxt = S_SHOW;
            S_SHOW:    if (OLED_FIN) state_nxt = S_RELEASE;
            S_RELEASE: if (!OLED_FIN) state_nxt = (DWELL_CYCLES == 0) ? S_IDLE : S_DWELL;
            S_DWELL:   if (cnt == '0) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            gnt_q  <= '0;
            done_q <= '0;
            en_q   <= 1'b0;
            str_q  <= '0;
            ptr    <= '0;
            cnt    <= '0;
        end else begin
            done_q <= '0;
            case (state)
                S_IDLE: begin
                    if (|REQ) begin
                        gnt_q <= {{(NREQ-1){1'b0}}, 1'b1} << win;
                        str_q <= REQ_STRING[512*win +: 512];
                        en_q  <= 1'b1;
                        if (!win_prio)
                            ptr <= (win == PW'(NREQ - 1)) ? '0 : win + 1'b1;
                    end
                end
                S_SHOW: begin
                    if (OLED_FIN) begin
                        en_q   <= 1'b0;
                        done_q <= gnt_q;
                    end
                end
                S_RELEASE: begin
                    if (!OLED_FIN) begin
                        if (DWELL_CYCLES == 0)
                            gnt_q <= '0;
                        else
                            cnt <= DWELL_LOAD;
                    end
                end
                S_DWELL: begin
                    if (cnt == '0)
                        gnt_q <= '0;
                    else
                        cnt <= cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        BUSY = (state != S_IDLE);
    end

    assign GNT         = gnt_q;
    assign DONE        = done_q;
    assign OLED_EN     = en_q;
    assign OLED_STRING = str_q;

endmodule

// File: tb/tb_oled_screen_arbiter.sv
// Directed bench for oled_screen_arbiter (NREQ=4, DWELL_CYCLES=10); prio-0 scenario only when OLED_ARB_PRIO0_EN is defined.
module tb_oled_screen_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 10;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic [3:0]    REQ = '0;
    logic [2047:0] REQ_STRING;
    logic [3:0]    GNT;
    logic [3:0]    DONE;
    logic          OLED_EN;
    logic          OLED_FIN = 1'b0;
    logic [511:0]  OLED_STRING;
    logic          BUSY;

    logic [511:0]  img [4];
    int            tests = 0;
    int            fails = 0;
    int            cyc   = 0;

    oled_screen_arbiter #(.NREQ(NREQ), .DWELL_CYCLES(DW)) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .REQ_STRING(REQ_STRING),
        .GNT(GNT), .DONE(DONE), .OLED_EN(OLED_EN), .OLED_FIN(OLED_FIN),
        .OLED_STRING(OLED_STRING), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        RST = 1'b0;
        REQ = '0;
        OLED_FIN = 1'b0;
        tick();
        tick();
        RST = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (GNT !== 4'b0) begin fails++; $display("FAIL reset_gnt: got %b expected 0000", GNT); end
        tests++; if (DONE !== 4'b0) begin fails++; $display("FAIL reset_done: got %b expected 0000", DONE); end
        tests++; if (OLED_EN !== 1'b0) begin fails++; $display("FAIL reset_en: got %b expected 0", OLED_EN); end
        tests++; if (OLED_STRING !== 512'b0) begin fails++; $display("FAIL reset_string: got nonzero expected 0"); end
        tests++; if (BUSY !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", BUSY); end
        tick();
        tests++; if (BUSY !== 1'b0) begin fails++; $display("FAIL idle_no_req_busy: got %b expected 0", BUSY); end
    endtask

    task automatic test_single();
        do_reset();
        REQ = 4'b0010;
        tick();
        REQ = 4'b0000;
        tests++; if ({GNT, OLED_EN, BUSY} !== {4'b0010, 1'b1, 1'b1}) begin
            fails++; $display("FAIL single_grant: got gnt=%b en=%b busy=%b expected gnt=0010 en=1 busy=1", GNT, OLED_EN, BUSY); end
        tests++; if (OLED_STRING !== img[1] || OLED_STRING[511:504] !== 8'h41) begin
            fails++; $display("FAIL single_string: got %h expected %h", OLED_STRING[511:480], img[1][511:480]); end
        repeat (49) tick();
        tests++; if ({OLED_EN, DONE} !== {1'b1, 4'b0000}) begin
            fails++; $display("FAIL single_show_hold: got en=%b done=%b expected en=1 done=0000", OLED_EN, DONE); end
        OLED_FIN = 1'b1;
        tick();
        tests++; if ({DONE, OLED_EN} !== {4'b0010, 1'b0}) begin
            fails++; $display("FAIL single_done: got done=%b en=%b expected done=0010 en=0", DONE, OLED_EN); end
        OLED_FIN = 1'b0;
        tick();
        tests++; if ({DONE, GNT} !== {4'b0000, 4'b0010}) begin
            fails++; $display("FAIL single_done_pulse: got done=%b gnt=%b expected done=0000 gnt=0010", DONE, GNT); end
        repeat (9) tick();
        tests++; if (GNT !== 4'b0010) begin fails++; $display("FAIL single_dwell_hold: got %b expected 0010", GNT); end
        tick();
        tests++; if ({GNT, BUSY} !== {4'b0000, 1'b0}) begin
            fails++; $display("FAIL single_dwell_end: got gnt=%b busy=%b expected gnt=0000 busy=0", GNT, BUSY); end
        tests++; if (OLED_STRING !== img[1]) begin fails++; $display("FAIL single_string_kept: got %h expected %h", OLED_STRING[511:480], img[1][511:480]); end
    endtask

    task automatic test_round_robin();
        logic [3:0] order [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        int last = 0;
        do_reset();
        REQ = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            int t = 0;
            while (GNT != 4'b0 && t < 100) begin tick(); t++; end
            while (GNT == 4'b0 && t < 200) begin tick(); t++; end
            tests++; if (GNT !== order[n]) begin fails++; $display("FAIL rr_order_%0d: got %b expected %b", n, GNT, order[n]); end
            if (n > 0) begin
                tests++; if (cyc - last !== 32) begin fails++; $display("FAIL rr_spacing_%0d: got %0d expected 32", n, cyc - last); end
            end
            last = cyc;
            repeat (19) tick();
            OLED_FIN = 1'b1;
            tick();
            OLED_FIN = 1'b0;
        end
        REQ = 4'b0000;
    endtask

    task automatic test_handshake();
        do_reset();
        REQ = 4'b0001;
        tick();
        REQ = 4'b0000;
        OLED_FIN = 1'b1;
        tick();
        tests++; if ({DONE, OLED_EN} !== {4'b0001, 1'b0}) begin
            fails++; $display("FAIL hs_done: got done=%b en=%b expected done=0001 en=0", DONE, OLED_EN); end
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++; if ({GNT, DONE, OLED_EN, BUSY} !== {4'b0001, 4'b0000, 1'b0, 1'b1}) begin
                fails++; $display("FAIL hs_release_%0d: got gnt=%b done=%b en=%b busy=%b expected gnt=0001 done=0000 en=0 busy=1",
                                  i, GNT, DONE, OLED_EN, BUSY); end
        end
        OLED_FIN = 1'b0;
        repeat (10) tick();
        tests++; if (GNT !== 4'b0001) begin fails++; $display("FAIL hs_dwell_hold: got %b expected 0001", GNT); end
        tick();
        tests++; if (GNT !== 4'b0000) begin fails++; $display("FAIL hs_dwell_end: got %b expected 0000", GNT); end
    endtask

    task automatic test_withdrawal();
        int t = 0;
        do_reset();
        REQ = 4'b1100;
        tick();
        tests++; if (GNT !== 4'b0100) begin fails++; $display("FAIL wd_grant: got %b expected 0100", GNT); end
        tick();
        REQ = 4'b1000;
        OLED_FIN = 1'b1;
        tick();
        OLED_FIN = 1'b0;
        tests++; if (DONE !== 4'b0100) begin fails++; $display("FAIL wd_done: got %b expected 0100", DONE); end
        while (GNT != 4'b0 && t < 50) begin tick(); t++; end
        while (GNT == 4'b0 && t < 100) begin tick(); t++; end
        tests++; if ({GNT, OLED_STRING} !== {4'b1000, img[3]}) begin
            fails++; $display("FAIL wd_next_grant: got %b expected 1000 with image 3", GNT); end
        REQ = 4'b0000;
    endtask

    task automatic test_reset_mid_show();
        do_reset();
        REQ = 4'b0010;
        tick();
        REQ = 4'b0000;
        #2;
        RST = 1'b0;
        #1;
        tests++; if ({GNT, OLED_EN, BUSY} !== {4'b0000, 1'b0, 1'b0}) begin
            fails++; $display("FAIL rst_async: got gnt=%b en=%b busy=%b expected gnt=0000 en=0 busy=0", GNT, OLED_EN, BUSY); end
        tests++; if (OLED_STRING !== 512'b0) begin fails++; $display("FAIL rst_async_string: got nonzero expected 0"); end
        RST = 1'b1;
        REQ = 4'b1010;
        tick();
        tests++; if (GNT !== 4'b0010) begin fails++; $display("FAIL rst_ptr_cleared: got %b expected 0010", GNT); end
        REQ = 4'b0000;
    endtask

`ifdef OLED_ARB_PRIO0_EN
    task automatic test_prio0();
        logic [3:0] exp_g [5] = '{4'b0001, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        do_reset();
        REQ = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            int t = 0;
            if (n == 2) REQ = 4'b1110;
            while (GNT != 4'b0 && t < 100) begin tick(); t++; end
            while (GNT == 4'b0 && t < 200) begin tick(); t++; end
            tests++; if (GNT !== exp_g[n]) begin fails++; $display("FAIL prio0_order_%0d: got %b expected %b", n, GNT, exp_g[n]); end
            OLED_FIN = 1'b1;
            tick();
            OLED_FIN = 1'b0;
        end
        REQ = 4'b0000;
    endtask
`endif

    initial begin
        for (int i = 0; i < 4; i++) begin
            img[i][511:504] = 8'h41;
            for (int b = 0; b < 63; b++) img[i][8*b +: 8] = 8'h30 + 8'(i);
            REQ_STRING[512*i +: 512] = img[i];
        end
        test_reset();
        test_single();
        test_round_robin();
        test_handshake();
        test_withdrawal();
        test_reset_mid_show();
`ifdef OLED_ARB_PRIO0_EN
        test_prio0();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
